cache_tag_plru: RTL

//  Parametrised N-way set-associative tag directory with tree pseudo-LRU replacement for the L1 cache

---
 rtl/cache_tag_plru.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/cache_tag_plru.sv
// rtl/cache_tag_plru.sv - N-way set-associative tag directory with tree pseudo-LRU replacement
//
// Purpose: holds valid/dirty/tag per way and PLRU bits per set for the L1 cache controller.
//          Answers lookups with the hit way, or on a miss with the victim way and its state.
//          Accepts single-cycle line fills. The data array and memory traffic stay in the controller.
// Ports:
//    clk, rst              clock, synchronous active-high reset
//    init_done             directory usable (sweep finished)
//    inv_all               pulse: invalidate whole directory by re-running the sweep
//    req_valid/req_ready   lookup handshake; req_addr byte address, req_we marks a write
//    rsp_*                 registered lookup result, one-cycle pulse on rsp_valid
//    fill_*                single-cycle line install (index, way, tag, initial dirty)
module cache_tag_plru #(
   parameter int ADDR_W = 32,
   parameter int TAGLSB = 12,
   parameter int SETS   = 64,
   parameter int WAYS   = 4,
   localparam int TAG_W   = ADDR_W - TAGLSB,
   localparam int INDEX_W = $clog2(SETS),
   localparam int WAY_W   = $clog2(WAYS)
) (
   input  logic               clk,
   input  logic               rst,
   output logic               init_done,
   input  logic               inv_all,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [ADDR_W-1:0]  req_addr,
   input  logic               req_we,
   output logic               rsp_valid,
   output logic               rsp_hit,
   output logic [WAY_W-1:0]   rsp_way,
   output logic               rsp_victim_valid,
   output logic               rsp_victim_dirty,
   output logic [TAG_W-1:0]   rsp_victim_tag,
   input  logic               fill_valid,
   input  logic [INDEX_W-1:0] fill_index,
   input  logic [WAY_W-1:0]   fill_way,
   input  logic [TAG_W-1:0]   fill_tag,
   input  logic               fill_dirty
);

   localparam int NODES = WAYS - 1;

   typedef enum logic {S_INIT, S_RUN} state_e;

   state_e             state_q, state_d;
   logic [INDEX_W-1:0] cnt_q, cnt_d;

   // Directory arrays: not reset, cleared set by set during the sweep.
   logic [WAYS-1:0]  valid_q [SETS];
   logic [WAYS-1:0]  dirty_q [SETS];
   logic [TAG_W-1:0] tag_q   [SETS][WAYS];
   logic [NODES-1:0] plru_q  [SETS];

   // Tree walks use a WAYS-wide padded copy of the node bits so a WAY_W-bit
   // heap index addresses it exactly; the top pad bit is never a real node.
   function automatic logic [WAY_W-1:0] plru_victim(input logic [NODES-1:0] bits);
      logic [WAYS-1:0]  pad;
      logic [WAY_W-1:0] node;
      logic [WAY_W-1:0] w;
      logic             b;
      pad  = {1'b0, bits};
      node = '0;
      w    = '0;
      for (int l = 0; l < WAY_W; l++) begin
         b    = pad[node];
         w    = (w << 1) | WAY_W'(b);
         node = (node << 1) + WAY_W'(1) + WAY_W'(b);
      end
      return w;
   endfunction

   // Every node on the path to 'way' is pointed at the opposite half.
   function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                    input logic [WAY_W-1:0] way);
      logic [WAYS-1:0]  pad;
      logic [WAY_W-1:0] node;
      logic [WAY_W-1:0] wsh;
      logic             b;
      pad  = {1'b0, bits};
      node = '0;
      wsh  = way;
      for (int l = 0; l < WAY_W; l++) begin
         b         = wsh[WAY_W-1];
         pad[node] = ~b;
         node      = (node << 1) + WAY_W'(1) + WAY_W'(b);
         wsh       = wsh << 1;
      end
      return pad[NODES-1:0];
   endfunction

   // ---------------- lookup datapath ----------------
   logic [INDEX_W-1:0] req_idx;
   logic [TAG_W-1:0]   req_tag;
   logic [WAYS-1:0]    hit_vec;
   logic               hit;
   logic [WAY_W-1:0]   hit_way;
   logic               any_inv;
   logic [WAY_W-1:0]   inv_way;
   logic [WAY_W-1:0]   vic_way;
   logic               vic_valid;
   logic               accept;
   logic               unused_addr_bits;

   assign req_idx          = req_addr[TAGLSB-1 -: INDEX_W];
   assign req_tag          = req_addr[ADDR_W-1:TAGLSB];
   assign unused_addr_bits = ^req_addr[TAGLSB-INDEX_W-1:0];

   always_comb begin
      hit_vec = '0;
      hit_way = '0;
      inv_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         hit_vec[w] = valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag);
      end
      // Descending scan so the lowest matching / lowest invalid way wins.
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (hit_vec[w]) hit_way = WAY_W'(w);
         if (!valid_q[req_idx][w]) inv_way = WAY_W'(w);
      end
      hit     = |hit_vec;
      any_inv = ~&valid_q[req_idx];
      vic_way = any_inv ? inv_way : plru_victim(plru_q[req_idx]);
   end

   assign vic_valid = valid_q[req_idx][vic_way];
   // rst is folded in so a lookup presented during reset never updates state.
   assign accept    = req_valid && req_ready && !rst;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_INIT: begin
            cnt_d = cnt_q + INDEX_W'(1);
            if (cnt_q == INDEX_W'(SETS - 1)) state_d = S_RUN;
         end
         S_RUN: begin
            if (inv_all) begin
               state_d = S_INIT;
               cnt_d   = '0;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      init_done = (state_q == S_RUN);
      req_ready = (state_q == S_RUN) && !fill_valid;
   end

   // ---------------- directory update ----------------
   // Fills and lookups are exclusive (req_ready drops while fill_valid).
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == S_INIT) begin
            valid_q[cnt_q] <= '0;
            dirty_q[cnt_q] <= '0;
            plru_q[cnt_q]  <= '0;
         end else if (fill_valid && !inv_all) begin
            valid_q[fill_index][fill_way] <= 1'b1;
            dirty_q[fill_index][fill_way] <= fill_dirty;
            tag_q[fill_index][fill_way]   <= fill_tag;
            plru_q[fill_index]            <= plru_touch(plru_q[fill_index], fill_way);
         end else if (accept && hit) begin
            plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
            if (req_we) dirty_q[req_idx][hit_way] <= 1'b1;
         end
      end
   end

   // ---------------- registered response ----------------
   // Victim dirty/tag are only reported for a valid victim; an invalid way's
   // tag is stale or never written.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid        <= 1'b0;
         rsp_hit          <= 1'b0;
         rsp_way          <= '0;
         rsp_victim_valid <= 1'b0;
         rsp_victim_dirty <= 1'b0;
         rsp_victim_tag   <= '0;
      end else begin
         rsp_valid        <= accept;
         rsp_hit          <= accept && hit;
         rsp_way          <= !accept ? '0 : (hit ? hit_way : vic_way);
         rsp_victim_valid <= accept && !hit && vic_valid;
         rsp_victim_dirty <= accept && !hit && vic_valid && dirty_q[req_idx][vic_way];
         rsp_victim_tag   <= (accept && !hit && vic_valid) ? tag_q[req_idx][vic_way] : '0;
      end
   end

endmodule
